// File: rtl/dtree_stream_pkg.sv
// Shared types and helpers for the decision-tree stream wrapper.
// Holds the FSM state encoding, default widths and a saturating increment.
package dtree_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int DEF_FEAT_W  = 8;
  localparam int DEF_CLASS_W = 2;
  localparam int DEF_CNT_W   = 16;
  localparam int MAX_CNT_W   = 32;

  // Counters up to MAX_CNT_W bits wide; callers zero-extend in and truncate out.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input int width);
    logic [MAX_CNT_W-1:0] max_val;
    max_val = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
    return (val >= max_val) ? val : val + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dtree_class_hist.sv
// Per-class result histogram plus a running total, all saturating.
// Clear has priority over a same-cycle increment.
module dtree_class_hist
  import dtree_stream_pkg::*;
#(
  parameter int CLASS_W = DEF_CLASS_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [CLASS_W-1:0] cls,
  input  logic               clr,
  input  logic [CLASS_W-1:0] sel,
  output logic [CNT_W-1:0]   cnt,
  output logic [CNT_W-1:0]   total
);

  localparam int NBINS = 1 << CLASS_W;

  logic [CNT_W-1:0] bin_val [NBINS];
  logic [CNT_W-1:0] total_reg;

  generate
    for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
      logic [CNT_W-1:0] bin_reg;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          bin_reg <= '0;
        end else if (inc && (cls == CLASS_W'(gi))) begin
          bin_reg <= CNT_W'(sat_inc(MAX_CNT_W'(bin_reg), CNT_W));
        end
      end

      assign bin_val[gi] = bin_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      total_reg <= '0;
    end else if (inc) begin
      total_reg <= CNT_W'(sat_inc(MAX_CNT_W'(total_reg), CNT_W));
    end
  end

  assign cnt   = bin_val[sel];
  assign total = total_reg;

endmodule

// File: rtl/dtree_stream_wrapper.sv
// Valid/ready wrapper around an external combinational tree classifier:
// registers the feature, waits for the tree to settle, holds the class, and histograms results.
module dtree_stream_wrapper
  import dtree_stream_pkg::*;
#(
  parameter int FEAT_W        = DEF_FEAT_W,
  parameter int CLASS_W       = DEF_CLASS_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FEAT_W-1:0]  in_data,
  output logic [FEAT_W-1:0]  feat_o,
  input  logic [CLASS_W-1:0] class_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  input  logic               hist_clr,
  input  logic [CLASS_W-1:0] hist_sel,
  output logic [CNT_W-1:0]   hist_cnt,
  output logic [CNT_W-1:0]   total_cnt
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [7:0]         settle_reg, settle_next;
  logic [FEAT_W-1:0]  feat_reg, feat_next;
  logic [CLASS_W-1:0] class_reg, class_next;
  logic               out_hs;

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    feat_next   = feat_reg;
    class_next  = class_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
      end
      SETTLE: begin
        if (settle_reg == 8'd0) begin
          class_next = class_i;
          state_next = HOLD;
        end else begin
          settle_next = settle_reg - 8'd1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A new sample overrides the HOLD->IDLE exit, giving back-to-back flow.
    if (in_valid && in_ready) begin
      feat_next   = in_data;
      settle_next = SETTLE_LOAD;
      state_next  = SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      settle_reg <= 8'd0;
      feat_reg   <= '0;
      class_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      feat_reg   <= feat_next;
      class_reg  <= class_next;
    end
  end

  assign out_hs    = out_valid && out_ready;
  assign feat_o    = feat_reg;
  assign out_class = class_reg;

  dtree_class_hist #(
    .CLASS_W(CLASS_W),
    .CNT_W  (CNT_W)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_hs),
    .cls  (class_reg),
    .clr  (hist_clr),
    .sel  (hist_sel),
    .cnt  (hist_cnt),
    .total(total_cnt)
  );

endmodule

// File: tb/tb_dtree_stream_wrapper.sv
// Scoreboard bench for dtree_stream_wrapper: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model.
module tb_dtree_stream_wrapper;

  localparam int FEAT_W  = 8;
  localparam int CLASS_W = 2;
  localparam int S       = 2;
  localparam int CNT_W   = 4;
  localparam int NB      = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [FEAT_W-1:0]  in_data;
  logic [FEAT_W-1:0]  feat_o;
  logic [CLASS_W-1:0] class_i;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic               hist_clr;
  logic [CLASS_W-1:0] hist_sel;
  logic [CNT_W-1:0]   hist_cnt;
  logic [CNT_W-1:0]   total_cnt;
  logic [1:0]         noise;

  always #5 clk = ~clk;

  // Stand-in for the external classifier; noise perturbs it to prove out_class is held.
  function automatic logic [1:0] tree(input logic [7:0] f);
    return f[7:6] ^ f[1:0];
  endfunction

  assign class_i = tree(feat_o) ^ noise;

  dtree_stream_wrapper #(
    .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .SETTLE_CYCLES(S), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .feat_o(feat_o), .class_i(class_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .hist_clr(hist_clr), .hist_sel(hist_sel),
    .hist_cnt(hist_cnt), .total_cnt(total_cnt)
  );

  typedef struct {
    int         acc;
    logic [1:0] cls;
  } item_t;

  item_t      q[$];
  int         bins_m[NB];
  int         total_m;
  logic [7:0] feat_m;
  logic [1:0] class_m;
  int         cyc = 0;
  bit         armed = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] dq[$];

  bit         ov_e, ir_e, ohs, ihs;
  logic [1:0] popped;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT against model, then advance the model for the coming edge.
  always @(negedge clk) begin
    ov_e = (q.size() > 0) && (cyc >= q[0].acc + S);
    ir_e = (q.size() == 0) || (ov_e && out_ready);
    if (armed) begin
      chk("in_ready", in_ready, ir_e);
      chk("out_valid", out_valid, ov_e);
      chk("out_class", out_class, class_m);
      chk("feat_o", feat_o, feat_m);
      chk("hist_cnt", hist_cnt, bins_m[hist_sel]);
      chk("total_cnt", total_cnt, total_m);
      $display("cyc=%0d in=%0b/%0b out=%0b/%0b cls=%0d tot=%0d", cyc, in_valid, in_ready,
               out_valid, out_ready, out_class, total_cnt);
    end
    if (rst) begin
      q.delete();
      for (int b = 0; b < NB; b++) bins_m[b] = 0;
      total_m = 0;
      feat_m  = '0;
      class_m = '0;
      armed   = 1'b1;
    end else if (armed) begin
      ohs = ov_e && out_ready;
      ihs = in_valid && ir_e;
      popped = '0;
      if (ohs) popped = q.pop_front().cls;
      if (hist_clr) begin
        for (int b = 0; b < NB; b++) bins_m[b] = 0;
        total_m = 0;
      end else if (ohs) begin
        if (bins_m[popped] < CMAX) bins_m[popped]++;
        if (total_m < CMAX) total_m++;
      end
      if (q.size() > 0 && (q[0].acc + S == cyc + 1)) class_m = q[0].cls;
      if (ihs) begin
        q.push_back('{cyc + 1, tree(in_data)});
        feat_m = in_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams dq back-to-back with out_ready high for ncyc clocks; reports output handshakes.
  task automatic stream(input int ncyc, output int n_out);
    int idx;
    idx = 0;
    n_out = 0;
    out_ready = 1'b1;
    in_valid = (dq.size() > 0);
    if (dq.size() > 0) in_data = dq[0];
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) n_out++;
      if (in_valid && in_ready) idx++;
      tick();
      if (idx < dq.size()) in_data = dq[idx];
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  int n;
  int tot_save;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    hist_clr = 1'b0; hist_sel = '0; noise = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Single sample 8'h5A -> class 3 after S clocks
    in_valid = 1'b1; in_data = 8'h5A; hist_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("single_feat", feat_o, 8'h5A);
    tick();
    chk("single_valid_early", out_valid, 1'b0);
    tick();
    chk("single_valid", out_valid, 1'b1);
    chk("single_class", out_class, 2'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_bin3", hist_cnt, 4'd1);
    chk("single_total", total_cnt, 4'd1);

    // Backpressure: class_i wiggles while the result is held
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    tot_save = int'(total_cnt);
    for (int k = 0; k < 10; k++) begin
      noise = 2'($urandom_range(1, 3));
      tick();
      chk("bp_class", out_class, 2'd0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_total", total_cnt, tot_save);
    end
    noise = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back: three results in nine clocks after the first accept
    dq = '{8'h10, 8'h20, 8'h30};
    stream(10, n);
    chk("b2b_results", n, 3);

    // Saturation at 2^CNT_W-1
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
    dq.delete();
    for (int k = 0; k < 17; k++) dq.push_back(8'h01);
    stream(56, n);
    chk("sat_results", n, 17);
    hist_sel = 2'd1;
    #1;
    chk("sat_bin1", hist_cnt, CMAX);
    chk("sat_total", total_cnt, CMAX);

    // Clear coinciding with an output handshake
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1; hist_clr = 1'b1;
    tick();
    out_ready = 1'b0; hist_clr = 1'b0;
    chk("clr_total", total_cnt, 4'd0);
    chk("clr_idle", in_ready, 1'b1);
    for (int b = 0; b < NB; b++) begin
      hist_sel = 2'(b);
      #1;
      chk("clr_bin", hist_cnt, 4'd0);
    end

    // Reset during the first SETTLE cycle drops the sample
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_feat", feat_o, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (5) tick();
    chk("rst_total", total_cnt, 4'd0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      hist_clr  = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 99) < 2);
      hist_sel  = 2'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; hist_clr = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtree_stream_wrapper.md
DTREE_STREAM_WRAPPER -- requirements
Module: dtree_stream_wrapper

Interface
REQ-001 SHALL have parameter FEAT_W, default 8: feature sample width.
REQ-002 SHALL have parameter CLASS_W, default 2: classifier class-label width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2: classifier settle time in clocks; legal range is 1 to 255.
REQ-004 SHALL have parameter CNT_W, default 16: histogram counter width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream offers a sample.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts the sample this cycle.
REQ-009 SHALL have port in_data, input, FEAT_W bits: feature sample.
REQ-010 SHALL have port feat_o, output, FEAT_W bits: registered feature driven to the external combinational tree classifier.
REQ-011 SHALL have port class_i, input, CLASS_W bits: class returned by the tree classifier.
REQ-012 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-014 SHALL have port out_class, output, CLASS_W bits: captured class.
REQ-015 SHALL have port hist_clr, input, 1 bit: clear all counters.
REQ-016 SHALL have port hist_sel, input, CLASS_W bits: histogram bin select.
REQ-017 SHALL have port hist_cnt, output, CNT_W bits: count of the selected bin (combinational read).
REQ-018 SHALL have port total_cnt, output, CNT_W bits: total results consumed.

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE and HOLD.
REQ-020 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, and 0 in SETTLE.
REQ-021 An input handshake (in_valid and in_ready) SHALL load feat_o with in_data, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-022 In SETTLE, feat_o SHALL stay stable; with counter 0 the block SHALL capture class_i into out_class, set out_valid, and go to HOLD; otherwise it SHALL decrement the counter.
REQ-023 Latency SHALL be exactly SETTLE_CYCLES clocks from the input-handshake edge to the edge that sets out_valid.
REQ-024 In HOLD, out_valid and out_class SHALL stay stable until out_ready is 1.
REQ-025 In HOLD, out_ready=1 with in_valid=0 SHALL clear out_valid and go to IDLE.
REQ-026 In HOLD, out_ready=1 with in_valid=1 SHALL clear out_valid, accept the new sample per REQ-021, and go to SETTLE with no idle bubble.
REQ-027 In IDLE, in_valid=0 SHALL hold state; feat_o SHALL retain the last accepted sample.
REQ-028 On each output handshake (out_valid and out_ready), bin[out_class] and total_cnt SHALL each increment by 1.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 hist_clr=1 SHALL zero all bins and total_cnt on the next edge; clear SHALL win over a simultaneous increment, and that result is not counted.
REQ-031 hist_clr SHALL NOT affect the FSM, feat_o or out_class.

Reset
REQ-032 rst=1 SHALL set, on the next edge: state to IDLE, out_valid 0, out_class 0, feat_o 0, settle counter 0, all bins 0, total_cnt 0.
REQ-033 Reset asserted during SETTLE or HOLD SHALL discard the in-flight sample without counting it; in_ready SHALL be 1 in the first cycle after reset releases.
REQ-034 rst SHALL take priority over every other input.

Structure
REQ-035 Package dtree_stream_pkg SHALL hold the FSM state enum, default FEAT_W/CLASS_W/CNT_W constants, and a saturating-increment function.
REQ-036 The per-class counters plus total_cnt SHALL be one sub-module, dtree_class_hist, with inputs inc, cls, clr and sel.
REQ-037 The tree classifier SHALL stay outside this block; the block SHALL NOT instantiate it.

Verification
REQ-038 Single sample, SETTLE_CYCLES=2: in_data=8'h5A accepted at edge 0; model class_i=2'd3 -> feat_o=8'h5A after edge 0; out_valid=1 and out_class=3 after edge 2; with out_ready=1, bin3=1 and total_cnt=1.
REQ-039 Backpressure: hold out_ready=0 for 10 cycles while class_i changes -> out_class is stable, in_ready=0, counters are unchanged.
REQ-040 Back-to-back, with in_valid and out_ready held at 1 and samples 8'h10, 8'h20, 8'h30 -> out_valid pulses every 3 clocks; 3 results in 9 clocks after the first accept; total_cnt=3.
REQ-041 Saturation, CNT_W=4: consume 17 results of class 1 -> bin1=15, total_cnt=15.
REQ-042 hist_clr asserted on the same edge as an output handshake -> all counters read 0 next cycle; the FSM returns to IDLE normally.
REQ-043 rst asserted in SETTLE cycle 1 -> out_valid never rises for that sample; feat_o=0; in_ready=1 one cycle after release; counters are 0.
